// File: rtl/regfile_writeback.sv
// Register-file write-port controller: merges ALU results (no backpressure,
// highest priority) with buffered mult/div results, and tracks registers that
// are still waiting on a mult/div result so the issue stage can stall.
module regfile_writeback #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                       clock,
    input  logic                       ctrl_reset,

    input  logic                       alu_valid,
    input  logic [ADDR_WIDTH-1:0]      alu_rd,
    input  logic [DATA_WIDTH-1:0]      alu_data,

    input  logic                       md_valid,
    output logic                       md_ready,
    input  logic [ADDR_WIDTH-1:0]      md_rd,
    input  logic [DATA_WIDTH-1:0]      md_data,

    input  logic                       issue_md,
    input  logic [ADDR_WIDTH-1:0]      issue_rd,
    input  logic [ADDR_WIDTH-1:0]      check_rs1,
    input  logic [ADDR_WIDTH-1:0]      check_rs2,
    input  logic [ADDR_WIDTH-1:0]      check_rd,
    output logic                       stall,
    output logic [(2**ADDR_WIDTH)-1:0] busy_mask,

    output logic                       ctrl_writeEnable,
    output logic [ADDR_WIDTH-1:0]      ctrl_writeReg,
    output logic [DATA_WIDTH-1:0]      data_writeReg
);

    localparam int unsigned NUM_REGS = 2 ** ADDR_WIDTH;
    localparam int unsigned PTR_W    = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W    = PTR_W + 1;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] rd;
        logic [DATA_WIDTH-1:0] data;
    } md_entry_t;

    // FIFO storage and pointers
    md_entry_t            fifo_q [FIFO_DEPTH];
    logic [PTR_W-1:0]     head_q, head_d;
    logic [PTR_W-1:0]     tail_q, tail_d;
    logic [CNT_W-1:0]     count_q, count_d;

    // Scoreboard
    logic [NUM_REGS-1:0]  busy_q, busy_d;

    // Registered write port
    logic                 we_q, we_d;
    logic [ADDR_WIDTH-1:0] wreg_q, wreg_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

    logic      fifo_full;
    logic      fifo_empty;
    logic      md_accept;
    logic      push;
    logic      pop;
    logic      alu_write;
    md_entry_t head_entry;

    // Handshake and write-select decode; a full FIFO never looks ahead at a pop
    assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign md_ready   = !fifo_full && !ctrl_reset;
    assign md_accept  = md_valid && md_ready;
    assign push       = md_accept && (md_rd != '0);
    assign alu_write  = alu_valid && (alu_rd != '0);
    assign pop        = !alu_write && !fifo_empty;
    assign head_entry = fifo_q[head_q];

    // Hazard check against the registered scoreboard, no bypass
    assign stall = busy_q[check_rs1] | busy_q[check_rs2] | busy_q[check_rd];

    assign busy_mask        = busy_q;
    assign ctrl_writeEnable = we_q;
    assign ctrl_writeReg    = wreg_q;
    assign data_writeReg    = wdata_q;

    // Next-state: FIFO pointers, scoreboard and write port
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        busy_d  = busy_q;
        we_d    = 1'b0;
        wreg_d  = wreg_q;
        wdata_d = wdata_q;

        if (push) begin
            tail_d = tail_q + PTR_W'(1);
        end
        if (pop) begin
            head_d = head_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);

        // Clear first so a same-edge issue to the same register keeps it busy
        if (pop) begin
            busy_d[head_entry.rd] = 1'b0;
        end
        if (issue_md && (issue_rd != '0)) begin
            busy_d[issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;

        if (alu_write) begin
            we_d    = 1'b1;
            wreg_d  = alu_rd;
            wdata_d = alu_data;
        end else if (pop) begin
            we_d    = 1'b1;
            wreg_d  = head_entry.rd;
            wdata_d = head_entry.data;
        end
    end

    // State registers
    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            busy_q  <= '0;
            we_q    <= 1'b0;
            wreg_q  <= '0;
            wdata_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            busy_q  <= busy_d;
            we_q    <= we_d;
            wreg_q  <= wreg_d;
            wdata_q <= wdata_d;
        end
    end

    // FIFO payload storage; validity is tracked by the pointers alone
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_q[tail_q] <= '{rd: md_rd, data: md_data};
        end
    end

endmodule
